// File: rtl/sink_ctrl_pkg.sv
// Shared types and sizing helpers for the sink RAM capture controller.
`default_nettype none

package sink_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sink_capture_ctrl.sv
// Restartable frame capture into the sink RAM: drops SKIP leading beats, writes
// FRAME_LEN bytes from address 0, and lends the RAM port to host reads when idle.
`default_nettype none

module sink_capture_ctrl
  import sink_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = 11,
  parameter int SKIP      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic              start_err
);

  localparam int                SKIP_W      = (clog2(SKIP + 1) > 0) ? clog2(SKIP + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST   = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_LEN - 1);
  localparam state_e            ENTRY_STATE = (SKIP > 0) ? ST_SKIP : ST_CAPTURE;

  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [SKIP_W-1:0]   skip_cnt_q,  skip_cnt_d;
  logic [ADDR_W:0]     wr_count_q,  wr_count_d;
  logic                rd_valid_q,  rd_valid_d;
  logic                start_err_q, start_err_d;

  logic                host_slot;
  logic                cap_write;

  // The RAM port belongs to the host only while no frame is in flight.
  assign host_slot = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign cap_write = (state_q == ST_CAPTURE) && data_valid;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    skip_cnt_d  = skip_cnt_q;
    wr_count_d  = wr_count_q;
    start_err_d = 1'b0;
    rd_valid_d  = rd_req && host_slot;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ENTRY_STATE;
          wr_ptr_d   = '0;
          skip_cnt_d = '0;
          wr_count_d = '0;
        end
      end
      ST_SKIP: begin
        start_err_d = start;
        if (data_valid) begin
          skip_cnt_d = skip_cnt_q + SKIP_W'(1);
          if (skip_cnt_q == SKIP_LAST) begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        start_err_d = start;
        if (data_valid) begin
          // wr_ptr wraps to 0 naturally when FRAME_LEN fills the address space.
          wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
          wr_count_d = wr_count_q + (ADDR_W + 1)'(1);
          if (wr_ptr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      skip_cnt_q  <= '0;
      wr_count_q  <= '0;
      rd_valid_q  <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      skip_cnt_q  <= skip_cnt_d;
      wr_count_q  <= wr_count_d;
      rd_valid_q  <= rd_valid_d;
      start_err_q <= start_err_d;
    end
  end

  // Capture and host grant are state-exclusive; capture is listed first anyway.
  always_comb begin
    ram_wren    = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    if (cap_write) begin
      ram_wren    = 1'b1;
      ram_address = wr_ptr_q;
      ram_data    = data_in;
    end else if (rd_req && host_slot) begin
      ram_address = rd_addr;
    end
  end

  assign rd_ready  = rd_req && host_slot;
  assign rd_data   = ram_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = (state_q == ST_SKIP) || (state_q == ST_CAPTURE);
  assign done      = (state_q == ST_DONE);
  assign wr_count  = wr_count_q;
  assign start_err = start_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sink_capture_ctrl.sv
// Randomised bench for sink_capture_ctrl with a behavioural RAM and frame model.
`default_nettype none

module tb_sink_capture_ctrl;

  localparam int T_SKIP = 3;
  localparam int T_FL   = 11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main instance (defaults)
  logic       start, data_valid, rd_req, rd_ready, rd_valid, ram_wren, busy, done, start_err;
  logic [7:0] data_in, rd_addr, rd_data, ram_address, ram_data, ram_q;
  logic [8:0] wr_count;

  // Wrap instance (SKIP=0, FRAME_LEN=256)
  logic       start2, data_valid2, rd_req2, rd_ready2, rd_valid2, ram_wren2, busy2, done2, start_err2;
  logic [7:0] data_in2, rd_addr2, rd_data2, ram_address2, ram_data2, ram_q2;
  logic [8:0] wr_count2;

  sink_capture_ctrl #(.ADDR_W(8), .DATA_W(8), .FRAME_LEN(T_FL), .SKIP(T_SKIP)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .data_valid(data_valid),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q), .busy(busy), .done(done),
    .wr_count(wr_count), .start_err(start_err)
  );

  sink_capture_ctrl #(.ADDR_W(8), .DATA_W(8), .FRAME_LEN(256), .SKIP(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .data_in(data_in2), .data_valid(data_valid2),
    .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_ready(rd_ready2), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .ram_address(ram_address2), .ram_data(ram_data2),
    .ram_wren(ram_wren2), .ram_q(ram_q2), .busy(busy2), .done(done2),
    .wr_count(wr_count2), .start_err(start_err2)
  );

  // Synchronous single-port RAMs, 1-cycle read latency
  logic [7:0] mem  [256];
  logic [7:0] mem2 [256];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
    if (ram_wren2) mem2[ram_address2] <= ram_data2;
    ram_q2 <= mem2[ram_address2];
  end

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  exp_mem  [256];
  logic [7:0]  exp_mem2 [256];
  logic [7:0]  stim_q [$];
  logic [15:0] wr_log [$];
  int          viol;
  int          err_pulses;
  bit          first_cycle;

  // Bus monitor for the main instance
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_wren) begin
        wr_log.push_back({ram_address, ram_data});
        if (!data_valid) viol++;
        if (rd_ready) viol++;
      end
      if (rd_ready && busy) viol++;
      if (busy && done) viol++;
      if (start_err) err_pulses++;
    end
  end

  task automatic step();
    @(negedge clk);
    if (first_cycle) begin
      checks++;
      if (busy !== 1'b1 || wr_count !== 9'd0) begin
        failures++;
        $display("FAIL after_start busy=%b wr_count=%0d required busy=1 wr_count=0", busy, wr_count);
      end
      first_cycle = 0;
    end
    @(posedge clk); #1;
  endtask

  // gap_mode: 0 none, 1 one idle cycle before each beat, 2 random 0..2 idle cycles
  task automatic run_frame(input int gap_mode, input int err_at, input bit hold_rd);
    int n, nw, gaps;
    bit exp_done;
    logic [15:0] exp_entry;
    bit log_ok;
    n = stim_q.size();
    nw = (n > T_SKIP) ? n - T_SKIP : 0;
    if (nw > T_FL) nw = T_FL;
    exp_done = (n >= T_SKIP + T_FL);
    wr_log.delete();
    viol = 0;
    err_pulses = 0;

    start = 1'b1;
    data_valid = 1'($urandom_range(0, 1));
    data_in = 8'($urandom);
    rd_req = hold_rd;
    rd_addr = 8'($urandom);
    @(negedge clk);
    if (hold_rd) begin
      checks++;
      if (rd_ready !== 1'b1) begin
        failures++;
        $display("FAIL grant_with_start rd_ready=%b required 1", rd_ready);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    first_cycle = 1;

    for (int i = 0; i < n; i++) begin
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) begin
        data_valid = 1'b0;
        data_in = 8'($urandom);
        step();
      end
      data_valid = 1'b1;
      data_in = stim_q[i];
      start = (i == err_at);
      step();
      start = 1'b0;
    end
    data_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== exp_done || busy !== !exp_done || wr_count !== 9'(nw)) begin
      failures++;
      $display("FAIL frame_end done=%b busy=%b wr_count=%0d required done=%b busy=%b wr_count=%0d",
               done, busy, wr_count, exp_done, !exp_done, nw);
    end
    if (hold_rd && exp_done) begin
      checks++;
      if (rd_ready !== 1'b1) begin
        failures++;
        $display("FAIL grant_first_done rd_ready=%b required 1", rd_ready);
      end
    end
    @(posedge clk); #1;
    rd_req = 1'b0;

    checks++;
    if (wr_log.size() != nw) begin
      failures++;
      $display("FAIL write_count writes=%0d required %0d", wr_log.size(), nw);
    end
    log_ok = 1;
    for (int k = 0; k < nw && k < wr_log.size(); k++) begin
      exp_entry = {8'(k), stim_q[T_SKIP + k]};
      if (log_ok && wr_log[k] !== exp_entry) begin
        log_ok = 0;
        $display("FAIL write_order idx=%0d got addr/data=%h required %h", k, wr_log[k], exp_entry);
      end
    end
    checks++;
    if (!log_ok) failures++;
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL bus_rules violations=%0d required 0", viol);
    end
    checks++;
    if (err_pulses != ((err_at >= 0) ? 1 : 0)) begin
      failures++;
      $display("FAIL start_err pulses=%0d required %0d", err_pulses, (err_at >= 0) ? 1 : 0);
    end
    for (int k = 0; k < nw; k++) exp_mem[k] = stim_q[T_SKIP + k];
  endtask

  task automatic read_back(input int n);
    for (int a = 0; a <= n; a++) begin
      rd_req = (a < n);
      rd_addr = 8'(a);
      @(negedge clk);
      if (a < n) begin
        checks++;
        if (rd_ready !== 1'b1 || ram_wren !== 1'b0) begin
          failures++;
          $display("FAIL read_grant addr=%0d rd_ready=%b ram_wren=%b required 1/0", a, rd_ready, ram_wren);
        end
      end
      if (a > 0) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_mem[a-1]) begin
          failures++;
          $display("FAIL read_data addr=%0d rd_valid=%b rd_data=%h required 1 %h",
                   a - 1, rd_valid, rd_data, exp_mem[a-1]);
        end
      end
      @(posedge clk); #1;
    end
    rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_valid_drop rd_valid=%b required 0", rd_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic fill_seq(input int base, input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(8'(base + i));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rd_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_count !== 9'd0 || rd_valid !== 1'b0 ||
        start_err !== 1'b0 || ram_wren !== 1'b0 || ram_address !== 8'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b wr_count=%0d rd_valid=%b start_err=%b wren=%b addr=%h required all 0",
               busy, done, wr_count, rd_valid, start_err, ram_wren, ram_address);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    fill_seq(8'h40, 14);
    run_frame(0, -1, 0);
    read_back(T_FL);
  endtask

  task automatic test_gapped();
    fill_seq(8'h10, 14);
    run_frame(1, -1, 0);
    read_back(T_FL);
  endtask

  task automatic test_restart_err();
    fill_seq(8'h20, 14);
    run_frame(0, T_SKIP + 4, 0);
    fill_seq(8'h80, 14);
    run_frame(0, -1, 0);
    read_back(T_FL);
  endtask

  task automatic test_arbitration();
    stim_q.delete();
    for (int i = 0; i < T_SKIP + T_FL; i++) stim_q.push_back(8'($urandom));
    run_frame(2, -1, 1);
    read_back(T_FL);
  endtask

  task automatic test_reset_mid_frame();
    stim_q.delete();
    for (int i = 0; i < T_SKIP + 4; i++) stim_q.push_back(8'($urandom));
    run_frame(0, -1, 0);
    data_valid = 1'b1;
    data_in = 8'($urandom);
    @(negedge clk);
    checks++;
    if (ram_wren !== 1'b1 || ram_address !== 8'd4) begin
      failures++;
      $display("FAIL pre_reset_write wren=%b addr=%0d required 1 4", ram_wren, ram_address);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (ram_wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wr_count !== 9'd0) begin
      failures++;
      $display("FAIL mid_reset wren=%b busy=%b done=%b wr_count=%0d required 0 0 0 0",
               ram_wren, busy, done, wr_count);
    end
    data_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    read_back(4);
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      stim_q.delete();
      for (int i = 0; i < T_SKIP + T_FL + int'($urandom_range(0, 3)); i++)
        stim_q.push_back(8'($urandom));
      run_frame(2, -1, 0);
      read_back(T_FL);
    end
  endtask

  task automatic test_wrap();
    int writes;
    writes = 0;
    start2 = 1'b1;
    data_valid2 = 1'b0;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        data_valid2 = 1'b0;
        @(negedge clk);
        if (ram_wren2) writes++;
        @(posedge clk); #1;
      end
      data_valid2 = 1'b1;
      data_in2 = 8'($urandom);
      exp_mem2[i] = data_in2;
      @(negedge clk);
      if (ram_wren2) writes++;
      @(posedge clk); #1;
    end
    data_valid2 = 1'b0;
    @(negedge clk);
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || wr_count2 !== 9'd256 || dut2.wr_ptr_q !== 8'd0) begin
      failures++;
      $display("FAIL wrap_end done=%b busy=%b wr_count=%0d wr_ptr=%0d required 1 0 256 0",
               done2, busy2, wr_count2, dut2.wr_ptr_q);
    end
    checks++;
    if (writes != 256) begin
      failures++;
      $display("FAIL wrap_writes writes=%0d required 256", writes);
    end
    @(posedge clk); #1;
    for (int a = 0; a <= 256; a++) begin
      rd_req2 = (a < 256);
      rd_addr2 = 8'(a);
      @(negedge clk);
      if (a > 0) begin
        checks++;
        if (rd_valid2 !== 1'b1 || rd_data2 !== exp_mem2[a-1]) begin
          failures++;
          $display("FAIL wrap_read addr=%0d rd_valid=%b rd_data=%h required 1 %h",
                   a - 1, rd_valid2, rd_data2, exp_mem2[a-1]);
        end
      end
      @(posedge clk); #1;
    end
    rd_req2 = 1'b0;
  endtask

  initial begin
    start = 1'b0; data_valid = 1'b0; data_in = '0; rd_req = 1'b0; rd_addr = '0;
    start2 = 1'b0; data_valid2 = 1'b0; data_in2 = '0; rd_req2 = 1'b0; rd_addr2 = '0;
    reset = 1'b1;
    first_cycle = 0;
    test_reset();
    test_basic();
    test_gapped();
    test_restart_err();
    test_arbitration();
    test_reset_mid_frame();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/sink_capture_ctrl.md
Name: sink_capture_ctrl

Overview:
- Sequences the sink RAM for a received byte stream. On a start pulse it drops the first SKIP valid bytes (demodulator pipeline fill), then writes FRAME_LEN bytes to consecutive RAM addresses from 0 and flags done.
- Shares the single-port sink RAM between this capture writer and a host readback port. Capture always has priority.
- Sits between the receive chain output and the synchronous single-port ram instance. It replaces free-running address counting with an explicit, restartable frame capture.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, byte width of stream and RAM.
- FRAME_LEN, 11, bytes captured per frame; legal range 1..2**ADDR_W.
- SKIP, 3, valid beats discarded after start before the first write; 0 is legal.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that arms a new capture.
- data_in  in  DATA_W  received byte.
- data_valid  in  1  data_in is valid this cycle.
- rd_req  in  1  host read request.
- rd_addr  in  ADDR_W  host read address.
- rd_ready  out  1  host request accepted this cycle.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data is valid.
- ram_address  out  ADDR_W  to ram.address.
- ram_data  out  DATA_W  to ram.data.
- ram_wren  out  1  to ram.wren.
- ram_q  in  DATA_W  from ram.q; registered, 1-cycle read latency.
- busy  out  1  high in SKIP or CAPTURE.
- done  out  1  high in DONE.
- wr_count  out  ADDR_W+1  bytes written in the current frame.
- start_err  out  1  one-cycle pulse when start arrives while busy.

Behaviour:
- Reset (async):
  - state=IDLE; wr_ptr, skip_cnt, wr_count = 0.
  - rd_valid, start_err = 0.
  - ram_wren is forced 0 immediately, including when reset is asserted mid-frame.
  - RAM contents are untouched.
- States and transitions:
  - IDLE --start--> SKIP if SKIP>0, else CAPTURE.
  - SKIP: each data_valid beat increments skip_cnt. When the SKIP-th beat is counted, go to CAPTURE. Skipped bytes are never written.
  - CAPTURE: each data_valid beat drives ram_wren=1, ram_address=wr_ptr, ram_data=data_in (combinational, same cycle) and increments wr_ptr and wr_count. The beat that writes address FRAME_LEN-1 moves the state to DONE on that edge.
  - DONE --start--> SKIP/CAPTURE, with wr_ptr, wr_count, skip_cnt cleared.
- Timing:
  - The first captured byte is the (SKIP+1)-th valid beat after the start cycle.
  - A data_valid beat in the same cycle as start is not counted.
  - Gaps in data_valid stall SKIP and CAPTURE without penalty.
- start while busy: ignored, state unchanged, start_err=1 for one cycle.
- Arbitration:
  - rd_ready = rd_req && state in {IDLE, DONE}. It is combinational.
  - On rd_ready: ram_address=rd_addr, ram_wren=0.
  - rd_valid=1 on the next cycle, with rd_data=ram_q.
  - During SKIP and CAPTURE, rd_ready=0; the host holds rd_req.
- Simultaneous start and rd_req in IDLE/DONE: the read is granted that cycle, and the state still advances on the edge.
- Default RAM drive when neither path is active: ram_wren=0, ram_address=0.
- wr_ptr is ADDR_W bits. With FRAME_LEN=2**ADDR_W it wraps to 0 on entering DONE; wr_count saturates at FRAME_LEN.
- busy and done are decoded from state, so they are never high together.

Decomposition:
- Package sink_ctrl_pkg:
  - state enum {IDLE, SKIP, CAPTURE, DONE}.
  - Default widths ADDR_W/DATA_W.
  - Function clog2 for sizing skip_cnt.
- No sub-module; the FSM, counters and arbitration mux live in one module. The ram instance is placed by the parent, alongside this block.

Test Plan:
- Basic capture: reset, start, then 14 consecutive valid bytes 0x40..0x4D -> RAM[0..10]=0x43..0x4D, done=1, wr_count=11. Reads of addr 0..10 return 0x43..0x4D with rd_valid exactly one cycle after rd_ready.
- Gapped valid: data_valid toggling 1/0 with 0x10..0x1D -> same mapping (RAM[0]=0x13); no write in any data_valid=0 cycle.
- Restart and error: start again in cycle 5 of CAPTURE -> start_err pulses once, capture unaffected. A new start in DONE followed by 0x80.. -> RAM[0]=0x83, wr_count restarts at 0.
- Arbitration: rd_req held from the start cycle onward -> rd_ready=0 through SKIP and CAPTURE, granted the first DONE cycle; no ram_wren in any granted cycle.
- Reset mid-frame: assert reset after 4 captured bytes -> ram_wren drops the same cycle, state=IDLE, wr_count=0, done=0; RAM[0..3] retain their values.
- SKIP=0, FRAME_LEN=256: 256 valid bytes -> first byte lands at RAM[0], wr_ptr wraps to 0, wr_count=256, done=1.
